mem_line_arbiter: RTL

//  Sits between the I-cache/D-cache and the unified line memory. Arbitrates one
//  4-word line transfer at a time: I-side refill (read) or D-side refill/write-back.

---
 rtl/mem_line_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: one-at-a-time 4-word line transfer between I/D caches and unified memory.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration on contention (default: D over I).
module mem_line_arbiter #(
  parameter int XLEN        = 32,
  parameter int WORDS       = 4,
  parameter int LADDR_BITS  = 8,
  parameter int MEM_LATENCY = 4,
  localparam int LW         = XLEN * WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [LADDR_BITS-1:0] ic_addr,
  output logic [LW-1:0]         ic_rdata,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [LADDR_BITS-1:0] dc_addr,
  input  logic [LW-1:0]         dc_wdata,
  output logic [LW-1:0]         dc_rdata,
  output logic                  dc_done,
  output logic [LADDR_BITS-1:0] mem_addr,
  output logic                  mem_we,
  output logic [LW-1:0]         mem_wdata,
  input  logic [LW-1:0]         mem_rdata,
  output logic                  busy
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  own_q, own_d;
  logic [LADDR_BITS-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [LW-1:0]         wdata_q, wdata_d;
  logic [LW-1:0]         ic_rdata_q, ic_rdata_d;
  logic [LW-1:0]         dc_rdata_q, dc_rdata_d;
  logic                  grant_dc;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  last_q, last_d;
  // last_q=1 means D was granted last; contention goes to the other side
  assign grant_dc = dc_req && (!ic_req || !last_q);
`else
  assign grant_dc = dc_req;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_d      = own_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: if (ic_req || dc_req) begin
        state_d = XFER;
        cnt_d   = CW'(MEM_LATENCY - 1);
        own_d   = grant_dc;
        addr_d  = grant_dc ? dc_addr : ic_addr;
        we_d    = grant_dc && dc_we;
        wdata_d = grant_dc ? dc_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = grant_dc;
`endif
      end
      XFER: begin
        cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d    = RESP;
          dc_rdata_d = !we_q && own_q ? mem_rdata : dc_rdata_q;
          ic_rdata_d = !we_q && !own_q ? mem_rdata : ic_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      own_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_q      <= own_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end
  assign busy      = state_q != IDLE;
  assign mem_addr  = state_q == XFER ? addr_q : '0;
  assign mem_we    = state_q == XFER && cnt_q == '0 && we_q;
  assign mem_wdata = wdata_q;
  assign ic_done   = state_q == RESP && !own_q;
  assign dc_done   = state_q == RESP && own_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
endmodule
